// File: rtl/switch_pkg.sv
// switch_pkg: shared defaults and helpers for the switch conditioner.
// No ports; imported by debounce_channel and switch_debounce_sync.
package switch_pkg;

   localparam int SW_DEBOUNCE_DEFAULT = 100000;
   localparam int SW_SYNC_DEFAULT     = 2;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/switch_debounce_sync_channel.sv
// debounce_channel: synchroniser, stability counter and edge flops for one switch.
// Ports: clk, rst (async low), i_sw_in raw level; o_sw debounced level,
// o_rise/o_fall registered pulses, o_rise_nxt/o_fall_nxt next-state pulses, o_agree.
module debounce_channel
   import switch_pkg::*;
#(
   parameter int   SYNC_STAGES     = SW_SYNC_DEFAULT,
   parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_sw_in,
   output logic o_sw,
   output logic o_rise,
   output logic o_fall,
   output logic o_rise_nxt,
   output logic o_fall_nxt,
   output logic o_agree
);

   localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_sw;
   logic                   r_rise;
   logic                   r_fall;

   logic w_sync_q;
   logic w_diff;
   logic w_accept;

   assign w_sync_q = r_sync[SYNC_STAGES-1];
   assign w_diff   = w_sync_q != r_sw;
   // Accept on the edge that would otherwise count to DEBOUNCE_CYCLES.
   assign w_accept = w_diff && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_sw   <= RESET_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw_in};
         r_rise <= w_accept &  w_sync_q;
         r_fall <= w_accept & ~w_sync_q;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt <= '0;
            r_sw  <= w_sync_q;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_sw       = r_sw;
   assign o_rise     = r_rise;
   assign o_fall     = r_fall;
   assign o_rise_nxt = w_accept &  w_sync_q;
   assign o_fall_nxt = w_accept & ~w_sync_q;
   assign o_agree    = ~w_diff;

endmodule

// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: N-channel switch synchroniser/debouncer with edge pulses.
// Ports: clk, rst (async low), sw_in raw levels; sw, sw_rise, sw_fall, sw_change, sw_stable.
module switch_debounce_sync
   import switch_pkg::*;
#(
   parameter int              N_SW            = 6,
   parameter int              SYNC_STAGES     = SW_SYNC_DEFAULT,
   parameter int              DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
   parameter logic [N_SW-1:0] RESET_VAL       = {N_SW{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] sw_in,
   output logic [N_SW-1:0] sw,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall,
   output logic            sw_change,
   output logic            sw_stable
);

   logic [N_SW-1:0] w_rise_nxt;
   logic [N_SW-1:0] w_fall_nxt;
   logic [N_SW-1:0] w_agree;
   logic            r_change;

   for (genvar i = 0; i < N_SW; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .RESET_VAL      (RESET_VAL[i])
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_sw_in   (sw_in[i]),
         .o_sw      (sw[i]),
         .o_rise    (sw_rise[i]),
         .o_fall    (sw_fall[i]),
         .o_rise_nxt(w_rise_nxt[i]),
         .o_fall_nxt(w_fall_nxt[i]),
         .o_agree   (w_agree[i])
      );
   end

   // Registered from next-state pulses so it lines up with sw_rise/sw_fall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_change <= 1'b0;
      end else begin
         r_change <= |{w_rise_nxt, w_fall_nxt};
      end
   end

   assign sw_change = r_change;
   assign sw_stable = &w_agree;

endmodule
